// File: rtl/multdiv_pkg.sv
// Shared constants for the multdiv issue controller: FSM state codes,
// instruction field positions and the R-type / ALU opcode defaults.
package multdiv_pkg;

   typedef logic [1:0] md_state_t;

   localparam md_state_t ST_IDLE     = 2'd0;
   localparam md_state_t ST_BUSY_MUL = 2'd1;
   localparam md_state_t ST_BUSY_DIV = 2'd2;
   localparam md_state_t ST_DONE     = 2'd3;

   localparam logic [4:0] OP_RTYPE      = 5'b00000;
   localparam logic [4:0] ALUOP_MUL_DEF = 5'b00110;
   localparam logic [4:0] ALUOP_DIV_DEF = 5'b00111;

   localparam int unsigned OPC_HI = 31;
   localparam int unsigned OPC_LO = 27;
   localparam int unsigned RD_HI  = 26;
   localparam int unsigned RD_LO  = 22;
   localparam int unsigned ALU_HI = 6;
   localparam int unsigned ALU_LO = 2;

endpackage

// File: rtl/md_watchdog.sv
// Busy-cycle counter for the multdiv controller: saturating count with
// clear/enable, forced-completion compare and the last-latency register.
module md_watchdog #(
   parameter int unsigned TIMEOUT = 64,
   parameter int unsigned CNT_W   = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             en,
   input  logic             cap,
   output logic             hit,
   output logic [CNT_W-1:0] last_lat
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
   localparam logic [CNT_W:0]   HIT_VAL = (CNT_W + 1)'(TIMEOUT - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] last_lat_q, last_lat_d;
   logic [CNT_W:0]   cnt_inc;

   // The count after this busy cycle; reaching TIMEOUT-1 here puts DONE
   // exactly TIMEOUT cycles after issue.
   assign cnt_inc = {1'b0, cnt_q} + 1'b1;
   assign hit     = en && (cnt_inc == HIT_VAL);

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_inc[CNT_W-1:0];
      end
   end

   always_comb begin
      last_lat_d = last_lat_q;
      if (cap) begin
         last_lat_d = cnt_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q      <= '0;
         last_lat_q <= '0;
      end else begin
         cnt_q      <= cnt_d;
         last_lat_q <= last_lat_d;
      end
   end

   assign last_lat = last_lat_q;

endmodule

// File: rtl/multdiv_issue_ctrl.sv
// Issue/completion controller for the iterative multiplier/divider: decodes
// DX, pulses start, stalls until ready or watchdog, then requests writeback.
module multdiv_issue_ctrl
   import multdiv_pkg::*;
#(
   parameter int unsigned TIMEOUT   = 64,
   parameter logic [4:0]  MUL_ALUOP = ALUOP_MUL_DEF,
   parameter logic [4:0]  DIV_ALUOP = ALUOP_DIV_DEF,
   parameter int unsigned CNT_W     = $clog2(TIMEOUT + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      dx_ir,
   input  logic             dx_valid,
   input  logic             unit_ready,
   input  logic             unit_exception,
   output logic             start_mul,
   output logic             start_div,
   output logic             stall,
   output logic             busy,
   output logic             wb_valid,
   output logic [4:0]       wb_rd,
   output logic             wb_exc,
   output logic             timeout,
   output logic [CNT_W-1:0] last_lat
);

   md_state_t  state_q, state_d;
   logic [4:0] rd_q, rd_d;
   logic       exc_q, exc_d;
   logic       to_q, to_d;

   logic [4:0] opc, alu, rd;
   logic       is_mul, is_div;
   logic       cnt_clr, cnt_en, cnt_cap, cnt_hit;
   logic       unused_ir;

   assign opc       = dx_ir[OPC_HI:OPC_LO];
   assign rd        = dx_ir[RD_HI:RD_LO];
   assign alu       = dx_ir[ALU_HI:ALU_LO];
   assign unused_ir = ^{dx_ir[21:7], dx_ir[1:0]};

   assign is_mul = dx_valid && (opc == OP_RTYPE) && (alu == MUL_ALUOP);
   assign is_div = dx_valid && (opc == OP_RTYPE) && (alu == DIV_ALUOP);

   md_watchdog #(
      .TIMEOUT (TIMEOUT),
      .CNT_W   (CNT_W)
   ) u_wdog (
      .clk      (clk),
      .reset    (reset),
      .clr      (cnt_clr),
      .en       (cnt_en),
      .cap      (cnt_cap),
      .hit      (cnt_hit),
      .last_lat (last_lat)
   );

   always_comb begin
      state_d   = state_q;
      rd_d      = rd_q;
      exc_d     = exc_q;
      to_d      = to_q;
      start_mul = 1'b0;
      start_div = 1'b0;
      cnt_clr   = 1'b0;
      cnt_en    = 1'b0;
      cnt_cap   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (is_mul || is_div) begin
               start_mul = is_mul;
               start_div = is_div;
               rd_d      = rd;
               exc_d     = 1'b0;
               to_d      = 1'b0;
               cnt_clr   = 1'b1;
               state_d   = is_mul ? ST_BUSY_MUL : ST_BUSY_DIV;
            end
         end
         ST_BUSY_MUL, ST_BUSY_DIV: begin
            cnt_en = 1'b1;
            // A ready arriving on the watchdog cycle is a real completion.
            if (unit_ready) begin
               exc_d   = unit_exception;
               to_d    = 1'b0;
               state_d = ST_DONE;
            end else if (cnt_hit) begin
               exc_d   = 1'b1;
               to_d    = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            cnt_cap = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         rd_q    <= '0;
         exc_q   <= 1'b0;
         to_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         rd_q    <= rd_d;
         exc_q   <= exc_d;
         to_q    <= to_d;
      end
   end

   assign busy     = (state_q == ST_BUSY_MUL) || (state_q == ST_BUSY_DIV);
   assign stall    = ((state_q == ST_IDLE) && (is_mul || is_div)) || busy;
   assign wb_valid = (state_q == ST_DONE);
   assign wb_rd    = wb_valid ? rd_q : '0;
   assign wb_exc   = wb_valid && exc_q;
   assign timeout  = wb_valid && to_q;

endmodule

// File: doc/multdiv_issue_ctrl.md
# multdiv_issue_ctrl

Parametrised issue/completion controller for the iterative multiplier/divider. It sits beside the DX pipeline register and decodes the DX instruction. On a mult or div it issues a one-cycle start pulse to the multdiv unit and holds the pipeline stalled until the unit reports ready or a watchdog expires. On completion it presents a one-cycle writeback request carrying the latched destination register and an exception flag.

## Interface
Parameters:
- `TIMEOUT`, 64: maximum number of busy cycles before forced completion; legal range 2..255.
- `MUL_ALUOP`, 5'b00110: ALU opcode for mult, with the R-type opcode equal to 5'b00000.
- `DIV_ALUOP`, 5'b00111: ALU opcode for div, with the R-type opcode equal to 5'b00000.
- `CNT_W`, $clog2(TIMEOUT+1): width of the busy-cycle counter.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `reset` in 1: synchronous, active-high.
- `dx_ir` in 32: instruction in DX. Opcode is [31:27], rd is [26:22], ALU op is [6:2].
- `dx_valid` in 1: DX holds a real, non-bubble instruction.
- `unit_ready` in 1: multdiv result valid; one-cycle pulse.
- `unit_exception` in 1: qualifies `unit_ready`; the operation raised an exception (divide by zero or overflow).
- `start_mul` out 1: one-cycle start pulse to the unit for a mult.
- `start_div` out 1: one-cycle start pulse to the unit for a div.
- `stall` out 1: freeze F/D/DX; combinational.
- `busy` out 1: an operation is in flight.
- `wb_valid` out 1: writeback request; one-cycle pulse.
- `wb_rd` out 5: destination register for the writeback.
- `wb_exc` out 1: the writeback carries an exception (rstatus path).
- `timeout` out 1: the watchdog fired; one-cycle pulse coincident with `wb_valid`.
- `last_lat` out CNT_W: busy-cycle count of the most recently completed operation.

## Operation
- Decode:
  - `is_mul` is true when `dx_valid`, opcode = 0 and ALU op = `MUL_ALUOP`.
  - `is_div` is the same test with `DIV_ALUOP`.
- FSM states: IDLE, BUSY_MUL, BUSY_DIV, DONE. Encodings live in the package.
- IDLE:
  - `is_mul` asserts `start_mul`, latches rd into `rd_q`, clears the counter and moves to BUSY_MUL.
  - `is_div` does the same with `start_div` and moves to BUSY_DIV.
  - `unit_ready` is ignored.
- BUSY_*:
  - The counter increments each cycle, saturating at `TIMEOUT`.
  - `unit_ready` moves to DONE and captures `exc_q = unit_exception`.
  - Otherwise, if the counter equals `TIMEOUT-1`, the FSM moves to DONE with `exc_q = 1` and a timeout flag set.
  - If `unit_ready` and the timeout condition occur in the same cycle, `unit_ready` wins and the timeout flag is not set.
- DONE:
  - `wb_valid = 1`, `wb_rd = rd_q`, `wb_exc = exc_q`, and `timeout` follows the timeout flag.
  - `last_lat` is updated with the counter value.
  - The FSM moves unconditionally to IDLE.
  - No start is issued in DONE, even though the same instruction is still in DX. This is what prevents re-issue.
- `stall = (IDLE & (is_mul | is_div)) | BUSY_MUL | BUSY_DIV`. `stall` is 0 in DONE, so the instruction leaves DX exactly when its result is written back.
- `busy` = BUSY_MUL | BUSY_DIV.
- rd = r0: the block still issues and writes back normally; suppressing the write to r0 is the register file's job.

## Timing
- Reset:
  - Next state is IDLE, and the counter, `rd_q`, `exc_q`, the timeout flag and `last_lat` are cleared.
  - `start_*`, `wb_valid`, `wb_exc`, `timeout` and `busy` are all 0 after reset. `wb_rd` and `last_lat` are 0.
  - A reset during BUSY abandons the operation; a later stray `unit_ready` in IDLE is ignored.
- Issue latency:
  - `start_*` and `stall` are asserted in the same cycle the decode hits in IDLE (combinational).
  - BUSY begins in the next cycle.
- Completion: for a `unit_ready` in cycle N, `wb_valid` is asserted and `stall` drops in cycle N+1. A new mult/div arriving in DX at N+2 is issued at N+2.
- Throughput: at most one operation in flight. Back-to-back mults cost (unit latency + 2) cycles each.
- Watchdog: the earliest forced completion is DONE at busy cycle `TIMEOUT`.
- `last_lat` holds the number of BUSY cycles, excluding the issue cycle.

## Structure
- Shared package `multdiv_pkg` holds:
  - the FSM state enum;
  - the opcode field constants: R-type opcode and the `MUL_ALUOP`/`DIV_ALUOP` defaults;
  - the instruction field bit positions.
- Sub-module `md_watchdog` contains the saturating counter with clear/enable, its compare against `TIMEOUT-1`, and the `last_lat` register.
- The FSM and decode stay in the top module.

## Test plan
- **Mult, ready after 3 busy cycles:** mult with rd=5 in DX; `unit_ready` asserted on busy cycle 3 with `unit_exception=0`.
  - Required: `start_mul` for 1 cycle.
  - Required: `stall` for 4 cycles.
  - Required: `wb_valid` with `wb_rd=5`, `wb_exc=0`, `last_lat=3`.
- **Div by zero:** div with rd=9; `unit_ready` and `unit_exception` asserted after 2 busy cycles.
  - Required: `start_div` only (no `start_mul`).
  - Required: `wb_rd=9`, `wb_exc=1`, `timeout=0`.
- **Timeout, `TIMEOUT=8`, unit never ready:**
  - Required: `wb_valid` with `wb_exc=1` and `timeout=1` at busy cycle 8.
  - Required: `last_lat=7`, `busy` deasserted the following cycle.
- **Ready/timeout tie:** `unit_ready` asserted in the same cycle the counter equals `TIMEOUT-1`.
  - Required: `timeout=0`, `wb_exc` = `unit_exception`.
- **Non-issue cases:** mult held in DX through DONE, and `dx_valid=0` carrying a mult encoding.
  - Required: no second `start_mul` during DONE.
  - Required: no start and no stall for the invalid DX slot.
  - Required: a non-mult R-type (add) never stalls.
- **Reset mid-op, then stray ready:** `reset` at busy cycle 2, then `unit_ready` in the following cycle.
  - Required: all outputs 0, state IDLE.
  - Required: no `wb_valid`.
  - Required: a fresh mult issues normally afterwards.
